// File: rtl/pipe_stage_buf.sv
// Elastic valid/ready pipeline-stage buffer: DEPTH-entry FIFO with flush,
// occupancy output and a saturating downstream-stall counter.
module pipe_stage_buf #(
    parameter int DATA_W      = 32,
    parameter int DEPTH       = 2,
    parameter int STALL_CNT_W = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush,
    input  logic                       up_valid,
    output logic                       up_ready,
    input  logic [DATA_W-1:0]          up_data,
    output logic                       dn_valid,
    input  logic                       dn_ready,
    output logic [DATA_W-1:0]          dn_data,
    output logic [$clog2(DEPTH):0]     occupancy,
    output logic [STALL_CNT_W-1:0]     stall_cnt
);
    localparam int AW = $clog2(DEPTH);
    localparam int OW = AW + 1;
    localparam logic [OW-1:0] FULL = OW'(DEPTH);

    logic [DATA_W-1:0]      mem_q [DEPTH];
    logic [AW-1:0]          wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]          rd_ptr_q, rd_ptr_d;
    logic [AW-1:0]          rd_nxt;
    logic [OW-1:0]          occ_q, occ_d;
    logic [STALL_CNT_W-1:0] stall_q, stall_d;
    logic [DATA_W-1:0]      dout_q, dout_d;
    logic                   push, pop;

    // Handshake outputs come from registered state only.
    assign up_ready  = (occ_q != FULL);
    assign dn_valid  = (occ_q != '0);
    assign dn_data   = dout_q;
    assign occupancy = occ_q;
    assign stall_cnt = stall_q;

    assign push   = up_valid && up_ready && !flush;
    assign pop    = dn_valid && dn_ready && !flush;
    assign rd_nxt = rd_ptr_q + AW'(1);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        occ_d    = occ_q;
        stall_d  = stall_q;
        dout_d   = dout_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            occ_d    = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + AW'(1);
            if (pop)  rd_ptr_d = rd_nxt;
            occ_d = occ_q + OW'(push) - OW'(pop);
        end
        if (dn_valid && !dn_ready && !flush && (stall_q != '1))
            stall_d = stall_q + STALL_CNT_W'(1);
        // dn_data is a register tracking the next head; it holds when the
        // buffer goes empty so the last value stays visible.
        if (push && (occ_q == '0))
            dout_d = up_data;
        else if (pop) begin
            if (occ_q > OW'(1))
                dout_d = mem_q[rd_nxt];
            else if (push)
                dout_d = up_data;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            occ_q    <= '0;
            stall_q  <= '0;
            dout_q   <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            occ_q    <= occ_d;
            stall_q  <= stall_d;
            dout_q   <= dout_d;
        end
    end

    // Storage needs no reset: occupancy gates every read.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= up_data;
    end
endmodule
